// File: rtl/psum_writeback_if.sv
// OFIFO-drain and psum SRAM port bundle for the psum writeback stage.
// The master side is the writeback engine; the slave side is the FIFO/SRAM
// environment that supplies rows and holds the psum memory.
interface psum_writeback_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
);
  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_out;
  logic                     ofifo_rd;
  logic                     mem_cen;
  logic                     mem_wen;
  logic [addr_bw-1:0]       mem_addr;
  logic [col*psum_bw-1:0]   mem_d;
  logic [col*psum_bw-1:0]   mem_q;

  modport master (
    input  ofifo_valid, ofifo_out, mem_q,
    output ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d
  );

  modport slave (
    output ofifo_valid, ofifo_out, mem_q,
    input  ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d
  );
endinterface

// File: rtl/psum_writeback.sv
// Drains psum rows from the corelet OFIFO into consecutive psum SRAM
// addresses. Overwrite mode streams one row per cycle; accumulate mode does a
// read-modify-write per row with lane-wise signed saturating addition.
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               acc_mode,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [addr_bw-1:0] num_rows,
  output logic               busy,
  output logic               done,
  psum_writeback_if.master   bus
);

  localparam int ROW_W = col * psum_bw;
  localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RDWAIT,
    S_WRITE,
    S_FIN
  } state_t;

  state_t             state, state_nxt;
  logic [addr_bw-1:0] addr_q, addr_nxt;
  logic [addr_bw-1:0] rem_q, rem_nxt;
  logic               acc_q, acc_nxt;
  logic               cen_q, cen_nxt;
  logic               wen_q, wen_nxt;
  logic [addr_bw-1:0] maddr_q, maddr_nxt;
  logic [ROW_W-1:0]   d_q, d_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               hold_ld;
  logic [ROW_W-1:0]   hold_q;
  logic [ROW_W-1:0]   sum_row;
  logic               pop;

  // Add two lanes at one extra bit and clamp to the signed lane range.
  function automatic logic signed [psum_bw-1:0] sat_add(
    input logic signed [psum_bw-1:0] a,
    input logic signed [psum_bw-1:0] b
  );
    logic signed [psum_bw:0] s;
    s = $signed({a[psum_bw-1], a}) + $signed({b[psum_bw-1], b});
    if (s[psum_bw] != s[psum_bw-1]) begin
      return s[psum_bw] ? SAT_MIN : SAT_MAX;
    end
    return s[psum_bw-1:0];
  endfunction

  // Pop is the only combinational output: a head row is consumed only in WAIT.
  assign pop          = (state == S_WAIT) && bus.ofifo_valid;
  assign bus.ofifo_rd = pop;
  assign bus.mem_cen  = cen_q;
  assign bus.mem_wen  = wen_q;
  assign bus.mem_addr = maddr_q;
  assign bus.mem_d    = d_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Lane-wise saturating sum of the stored row and the held OFIFO row.
  always_comb begin
    sum_row = '0;
    for (int i = 0; i < col; i++) begin
      sum_row[i*psum_bw +: psum_bw] = sat_add(bus.mem_q[i*psum_bw +: psum_bw],
                                              hold_q[i*psum_bw +: psum_bw]);
    end
  end

  // Next-state and next registered outputs; SRAM defaults to idle every cycle.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    acc_nxt   = acc_q;
    cen_nxt   = 1'b1;
    wen_nxt   = 1'b1;
    maddr_nxt = maddr_q;
    d_nxt     = d_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    hold_ld   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            done_nxt = 1'b1;
          end else begin
            addr_nxt  = base_addr;
            rem_nxt   = num_rows;
            acc_nxt   = acc_mode;
            busy_nxt  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (pop) begin
          cen_nxt   = 1'b0;
          maddr_nxt = addr_q;
          if (acc_q) begin
            hold_ld   = 1'b1;
            state_nxt = S_RDWAIT;
          end else begin
            wen_nxt  = 1'b0;
            d_nxt    = bus.ofifo_out;
            addr_nxt = addr_q + addr_bw'(1);
            rem_nxt  = rem_q - addr_bw'(1);
            if (rem_q == addr_bw'(1)) begin
              state_nxt = S_FIN;
            end
          end
        end
      end
      S_RDWAIT: begin
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        cen_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        maddr_nxt = addr_q;
        d_nxt     = sum_row;
        addr_nxt  = addr_q + addr_bw'(1);
        rem_nxt   = rem_q - addr_bw'(1);
        state_nxt = (rem_q == addr_bw'(1)) ? S_FIN : S_WAIT;
      end
      S_FIN: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and every registered output; reset aborts any job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      acc_q   <= 1'b0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      maddr_q <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      rem_q   <= rem_nxt;
      acc_q   <= acc_nxt;
      cen_q   <= cen_nxt;
      wen_q   <= wen_nxt;
      maddr_q <= maddr_nxt;
      d_q     <= d_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Popped row held for the accumulate add two cycles later.
  always_ff @(posedge clk) begin
    if (hold_ld) begin
      hold_q <= bus.ofifo_out;
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: OFIFO and SRAM environment models, a job-level
// reference (expected write/read lists and busy/done timing) checked every
// cycle, and directed scenarios with literal expectations.
module tb_psum_writeback;

  localparam int W  = 128;
  localparam int AW = 11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  d;
  } wr_t;

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] addr;
    logic [W-1:0]  d;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          acc_mode;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_rows;
  logic          busy;
  logic          done;

  psum_writeback_if #(.col(8), .psum_bw(16), .addr_bw(AW)) bus ();

  psum_writeback #(.col(8), .psum_bw(16), .addr_bw(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .acc_mode  (acc_mode),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int pops   = 0;

  logic [W-1:0]  sram    [2048];
  logic [W-1:0]  ref_mem [2048];
  logic [W-1:0]  fifo_q  [$];
  logic [W-1:0]  job_rows[$];
  bit            gate_pat[$];
  bit            gate;
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  ev_t           wr_log[$];
  ev_t           rd_log[$];
  int            done_log[$];

  bit            rd_s  = 1'b0;
  bit            cen_s = 1'b1;
  bit            wen_s = 1'b1;
  logic [AW-1:0] addr_s;
  logic [W-1:0]  d_s;
  bit            loaded = 1'b0;

  bit model_busy = 1'b0;
  bit pend_done  = 1'b0;
  bit model_acc  = 1'b0;
  bit rd_h1 = 1'b0, rd_h2 = 1'b0, rd_h3 = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] init_row(input int a);
    case (a)
      5:       return 128'h0000_0000_0000_0000_0000_0003_8005_7FF0;
      'h100:   return 128'h7FFF_0001_8000_1234_0000_FFFF_4000_0010;
      'h101:   return 128'h8000_8000_8000_8000_8000_8000_8000_8000;
      'h102:   return 128'h0100_0200_0300_0400_0500_0600_0700_0800;
      default: return '0;
    endcase
  endfunction

  // Reference accumulate: plain integer add per lane, clamped to 16-bit signed.
  function automatic logic [W-1:0] sat_row(input logic [W-1:0] m, input logic [W-1:0] h);
    int s;
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = int'($signed(m[i*16 +: 16])) + int'($signed(h[i*16 +: 16]));
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[i*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  // Environment: SRAM (read data one cycle later) and OFIFO pop, using the
  // bus values captured at the preceding falling edge.
  always @(posedge clk) begin
    logic [W-1:0] tmp;
    if (!loaded) begin
      for (int a = 0; a < 2048; a++) sram[a] = init_row(a);
      loaded = 1'b1;
    end
    if (rd_s) begin
      if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
      pops++;
    end
    if (!cen_s && !wen_s) sram[addr_s] = d_s;
    if (!cen_s && wen_s) bus.mem_q <= sram[addr_s];
  end

  // Compare process: every cycle, check the DUT against the job-level model.
  always @(negedge clk) begin
    bit wr_now, rdop_now, last, nb, pd;
    wr_t e;
    logic [AW-1:0] ea;
    cyc++;
    rd_s   = bus.ofifo_rd;
    cen_s  = bus.mem_cen;
    wen_s  = bus.mem_wen;
    addr_s = bus.mem_addr;
    d_s    = bus.mem_d;
    if (!reset) begin
      chk("reset_ctrl", {rd_s, cen_s, wen_s, addr_s, busy, done}, {1'b0, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0});
      chk("reset_mem_d", d_s, '0);
      model_busy = 1'b0;
      pend_done  = 1'b0;
      rd_h1 = 1'b0; rd_h2 = 1'b0; rd_h3 = 1'b0;
    end else begin
      wr_now   = !cen_s && !wen_s;
      rdop_now = !cen_s && wen_s;
      last     = 1'b0;
      chk("busy", busy, model_busy);
      chk("done", done, pend_done);
      if (rd_s) chk("pop_needs_valid_and_job", {bus.ofifo_valid, model_busy}, 2'b11);
      chk("write_slot", wr_now, model_acc ? rd_h3 : rd_h1);
      chk("read_slot", rdop_now, model_acc ? rd_h1 : 1'b0);
      if (wr_now) begin
        wr_log.push_back('{cyc, addr_s, d_s});
        chk("write_expected", exp_wr.size() != 0, 1'b1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("write_addr", addr_s, e.addr);
          chk("write_data", d_s, e.d);
          last = (exp_wr.size() == 0);
        end
      end
      if (rdop_now) begin
        rd_log.push_back('{cyc, addr_s, '0});
        chk("read_expected", exp_rd.size() != 0, 1'b1);
        if (exp_rd.size() != 0) begin
          ea = exp_rd.pop_front();
          chk("read_addr", addr_s, ea);
        end
      end
      if (done) done_log.push_back(cyc);
      nb = model_busy;
      pd = 1'b0;
      if (model_busy) begin
        if (wr_now && last) begin
          nb = 1'b0;
          pd = 1'b1;
        end
      end else if (start) begin
        if (num_rows == '0) pd = 1'b1;
        else begin
          nb = 1'b1;
          model_acc = acc_mode;
        end
      end
      rd_h3 = rd_h2; rd_h2 = rd_h1; rd_h1 = rd_s;
      model_busy = nb;
      pend_done  = pd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (gate_pat.size() != 0) gate = gate_pat.pop_front();
    else gate = 1'b1;
    bus.ofifo_valid = gate && (fifo_q.size() != 0);
    bus.ofifo_out   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // Queue the job's rows, derive its expected reads/writes, pulse start.
  task automatic launch(input logic [AW-1:0] base, input logic [AW-1:0] n, input bit acc);
    logic [AW-1:0] a;
    logic [W-1:0] nv;
    a = base;
    wr_log.delete();
    rd_log.delete();
    for (int i = 0; i < int'(n); i++) begin
      fifo_q.push_back(job_rows[i]);
      if (acc) begin
        exp_rd.push_back(a);
        nv = sat_row(ref_mem[a], job_rows[i]);
      end else begin
        nv = job_rows[i];
      end
      exp_wr.push_back('{a, nv});
      ref_mem[a] = nv;
      a = a + 11'd1;
    end
    start = 1'b1; base_addr = base; num_rows = n; acc_mode = acc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, k;
    d0 = done_log.size();
    k = 0;
    while (done_log.size() == d0 && k < budget) begin
      step();
      k++;
    end
    chk({name, "_done_in_budget"}, done_log.size() > d0, 1'b1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p0, d0, k;
    reset = 1'b0; start = 1'b0; acc_mode = 1'b0; base_addr = '0; num_rows = '0; gate = 1'b1;
    bus.ofifo_valid = 1'b0;
    bus.ofifo_out   = '0;
    for (int a = 0; a < 2048; a++) ref_mem[a] = init_row(a);
    chk("model_sat_pin",
        sat_row(init_row(5), 128'h0000_0000_0000_0000_0000_0004_FFF0_0020),
        128'h0000_0000_0000_0000_0000_0007_8000_7FFF);
    chk("model_sat_pin_min", sat_row(init_row('h101), {8{16'hFFFF}}), {8{16'h8000}});
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // Overwrite burst
    job_rows = '{128'h0001_0002_0003_0004_0005_0006_0007_0008,
                 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                 128'hA0A0_B1B1_C2C2_D3D3_E4E4_F5F5_0606_1717,
                 128'hFFFF_0000_8000_7FFF_0001_FFFE_1234_5678};
    p0 = pops; d0 = done_log.size();
    launch(11'h010, 11'd4, 1'b0);
    wait_done("burst", 20);
    chk("burst_pops", pops - p0, 4);
    chk("burst_nwrites", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("burst_addr%0d", i), wr_log[i].addr, 11'h010 + i);
        chk($sformatf("burst_data%0d", i), wr_log[i].d, job_rows[i]);
        chk($sformatf("burst_cycle%0d", i), wr_log[i].cyc - wr_log[0].cyc, i);
      end
      if (done_log.size() > d0) chk("burst_done_lat", done_log[d0] - wr_log[3].cyc, 1);
    end

    // Accumulate with saturation
    job_rows = '{128'h0000_0000_0000_0000_0000_0004_FFF0_0020};
    launch(11'h005, 11'd1, 1'b1);
    wait_done("acc_sat", 20);
    chk("acc_nwrites", wr_log.size(), 1);
    chk("acc_nreads", rd_log.size(), 1);
    if (wr_log.size() == 1 && rd_log.size() == 1) begin
      chk("acc_rd_addr", rd_log[0].addr, 11'h005);
      chk("acc_wr_addr", wr_log[0].addr, 11'h005);
      chk("acc_lane0", wr_log[0].d[15:0], 16'h7FFF);
      chk("acc_lane1", wr_log[0].d[31:16], 16'h8000);
      chk("acc_lane2", wr_log[0].d[47:32], 16'h0007);
      chk("acc_rd_to_wr", wr_log[0].cyc - rd_log[0].cyc, 2);
    end

    // Accumulate multi-row at full rate
    job_rows = '{128'h0001_7FFF_8000_0000_1111_FFFF_4000_FFF0,
                 {8{16'hFFFF}},
                 128'h0F00_0E00_0D00_0C00_0B00_0A00_0900_0800};
    launch(11'h100, 11'd3, 1'b1);
    wait_done("acc_multi", 30);
    chk("accm_nwrites", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("accm_row1_min", wr_log[1].d, {8{16'h8000}});
      chk("accm_rate01", wr_log[1].cyc - wr_log[0].cyc, 3);
      chk("accm_rate12", wr_log[2].cyc - wr_log[1].cyc, 3);
    end

    // Stall
    job_rows = '{128'h0000_0000_0000_0000_0000_0000_0000_00A1,
                 128'h0000_0000_0000_0000_0000_0000_0000_00A2,
                 128'h0000_0000_0000_0000_0000_0000_0000_00A3};
    gate_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    p0 = pops;
    launch(11'h020, 11'd3, 1'b0);
    wait_done("stall", 30);
    chk("stall_pops", pops - p0, 3);
    chk("stall_nwrites", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("stall_gap", wr_log[1].cyc - wr_log[0].cyc, 3);
      chk("stall_back2back", wr_log[2].cyc - wr_log[1].cyc, 1);
    end

    // Address wrap
    job_rows = '{128'hDEAD_0000_0000_0000_0000_0000_0000_0001,
                 128'hBEEF_0000_0000_0000_0000_0000_0000_0002};
    launch(11'h7FF, 11'd2, 1'b0);
    wait_done("wrap", 20);
    chk("wrap_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("wrap_addr0", wr_log[0].addr, 11'h7FF);
      chk("wrap_addr1", wr_log[1].addr, 11'h000);
    end

    // Zero-length job
    p0 = pops; d0 = done_log.size();
    launch(11'h050, 11'd0, 1'b0);
    wait_done("zero", 5);
    repeat (3) step();
    chk("zero_pops", pops - p0, 0);
    chk("zero_nwrites", wr_log.size(), 0);
    chk("zero_one_done", done_log.size() - d0, 1);

    // Reset mid-job
    job_rows = '{128'h1, 128'h2, 128'h3, 128'h4, 128'h5};
    p0 = pops;
    launch(11'h400, 11'd5, 1'b0);
    k = 0;
    while (pops - p0 < 2 && k < 20) begin
      step();
      k++;
    end
    chk("midreset_two_pops", pops - p0, 2);
    #1;
    reset = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    fifo_q.delete();
    #1;
    chk("async_reset_now", {bus.ofifo_rd, bus.mem_cen, bus.mem_wen, bus.mem_addr, busy, done},
        {1'b0, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0});
    repeat (2) step();
    reset = 1'b1;
    fifo_q.push_back(128'hAAAA);
    fifo_q.push_back(128'hBBBB);
    wr_log.delete();
    p0 = pops;
    repeat (5) step();
    chk("post_reset_no_pops", pops - p0, 0);
    chk("post_reset_no_writes", wr_log.size(), 0);
    fifo_q.delete();
    job_rows = '{128'h0000_0000_0000_0000_0000_0000_0000_C0DE};
    launch(11'h480, 11'd1, 1'b0);
    wait_done("after_reset", 20);
    chk("after_reset_nwrites", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("after_reset_addr", wr_log[0].addr, 11'h480);

    // Start while busy
    job_rows = '{128'h71, 128'h72, 128'h73, 128'h74};
    gate_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    p0 = pops; d0 = done_log.size();
    launch(11'h200, 11'd4, 1'b0);
    step();
    start = 1'b1; base_addr = 11'h300; num_rows = 11'd2; acc_mode = 1'b1;
    step();
    start = 1'b0;
    wait_done("busy_start", 30);
    repeat (4) step();
    chk("busy_start_pops", pops - p0, 4);
    chk("busy_start_nwrites", wr_log.size(), 4);
    chk("busy_start_one_done", done_log.size() - d0, 1);
    if (wr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("busy_start_addr%0d", i), wr_log[i].addr, 11'h200 + i);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
